// File: rtl/fft256_pkg.sv
// Shared types and default sizing for the FFT256 stage-3 frame controller.
// Sizing constants follow the default N and TIMEOUT values.
package fft256_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int N_DEF       = 256;
  localparam int TIMEOUT_DEF = 1023;

  localparam int N_LOG2      = $clog2(N_DEF);
  localparam int FRAME_CNT_W = 16;
  localparam int TO_CNT_W    = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/fft256_frame_ctrl_out_framer.sv
// Output-side framing: registers the stage output, tracks the in-frame
// position, emits sop/eop, counts frames and flags a stream that drops mid-frame.
module fft256_out_framer
  import fft256_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   do_en_i,
  input  logic [WIDTH-1:0]       do_re_i,
  input  logic [WIDTH-1:0]       do_im_i,
  output logic                   out_valid_o,
  output logic                   out_sop_o,
  output logic                   out_eop_o,
  output logic [WIDTH-1:0]       out_re_o,
  output logic [WIDTH-1:0]       out_im_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   drop_err_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

  logic [CW-1:0]          out_cnt_q, out_cnt_d;
  logic                   valid_q, valid_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [WIDTH-1:0]       re_q, re_d;
  logic [WIDTH-1:0]       im_q, im_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic                   drop;

  always_comb begin
    out_cnt_d = out_cnt_q;
    drop      = 1'b0;
    valid_d   = do_en_i;
    sop_d     = do_en_i && (out_cnt_q == '0);
    eop_d     = do_en_i && (out_cnt_q == LAST_SLOT);
    re_d      = do_en_i ? do_re_i : '0;
    im_d      = do_en_i ? do_im_i : '0;
    frame_d   = frame_q + FRAME_CNT_W'(eop_d);

    if (do_en_i) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (valid_q && (out_cnt_q != '0)) begin
      // Stage stream stopped part-way through a frame: realign on the next sample.
      drop      = 1'b1;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      frame_q   <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      re_q      <= re_d;
      im_q      <= im_d;
      frame_q   <= frame_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_sop_o   = sop_q;
  assign out_eop_o   = eop_q;
  assign out_re_o    = re_q;
  assign out_im_o    = im_q;
  assign frame_cnt_o = frame_q;
  assign drop_err_o  = drop;

endmodule

// File: rtl/fft256_frame_ctrl.sv
// Frame sequencer for the 256-point SDF stage: aligns input frames on sop,
// feeds the stage unbroken N-sample bursts and frames the stage output.
module fft256_frame_ctrl
  import fft256_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clr_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sop,
  input  logic [WIDTH-1:0]       in_re,
  input  logic [WIDTH-1:0]       in_im,
  output logic                   stg_di_en,
  output logic [WIDTH-1:0]       stg_di_re,
  output logic [WIDTH-1:0]       stg_di_im,
  input  logic                   stg_do_en,
  input  logic [WIDTH-1:0]       stg_do_re,
  input  logic [WIDTH-1:0]       stg_do_im,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [WIDTH-1:0]       out_re,
  output logic [WIDTH-1:0]       out_im,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy,
  output logic                   underrun_err,
  output logic                   sop_err,
  output logic                   timeout_err
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic             di_en_q, di_en_d;
  logic [WIDTH-1:0] di_re_q, di_re_d;
  logic [WIDTH-1:0] di_im_q, di_im_d;
  logic [1:0]       outstanding_q, outstanding_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             underrun_q, underrun_d;
  logic             sop_err_q, sop_err_d;
  logic             timeout_q, timeout_d;

  logic set_underrun, set_sop, frame_end, timeout_fire;
  logic boundary, drop_err, out_eop_w;

  // In RUN, in_cnt wraps to 0 after slot N-1; that cycle is the slot where the
  // next frame's sop must arrive for a gap-free back-to-back burst.
  assign boundary = (in_cnt_q == '0);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_ARM:  in_ready = enable;
      ST_RUN:  in_ready = boundary ? enable : 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    di_en_d      = 1'b0;
    di_re_d      = '0;
    di_im_d      = '0;
    set_underrun = 1'b0;
    set_sop      = 1'b0;
    frame_end    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (in_valid && in_sop) begin
          di_en_d  = 1'b1;
          di_re_d  = in_re;
          di_im_d  = in_im;
          in_cnt_d = CW'(1);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          if (in_valid && in_ready && in_sop) begin
            di_en_d  = 1'b1;
            di_re_d  = in_re;
            di_im_d  = in_im;
            in_cnt_d = CW'(1);
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          di_en_d  = 1'b1;
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_valid) begin
            di_re_d = in_re;
            di_im_d = in_im;
            set_sop = in_sop;
          end else begin
            set_underrun = 1'b1;
          end
          if (in_cnt_q == LAST_SLOT) begin
            frame_end = 1'b1;
            if (!enable) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == 2'd0) || timeout_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign timeout_fire = (outstanding_q != 2'd0) && (to_cnt_q == TW'(TIMEOUT));

  always_comb begin
    outstanding_d = outstanding_q + 2'(frame_end) - 2'(out_eop_w);
    to_cnt_d      = '0;
    if (timeout_fire) begin
      outstanding_d = 2'd0;
    end else if (!frame_end && !out_eop_w && (outstanding_q != 2'd0)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    underrun_d = set_underrun | (underrun_q & ~clr_err);
    sop_err_d  = set_sop | drop_err | (sop_err_q & ~clr_err);
    timeout_d  = timeout_fire | (timeout_q & ~clr_err);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      in_cnt_q      <= '0;
      di_en_q       <= 1'b0;
      di_re_q       <= '0;
      di_im_q       <= '0;
      outstanding_q <= 2'd0;
      to_cnt_q      <= '0;
      underrun_q    <= 1'b0;
      sop_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      di_en_q       <= di_en_d;
      di_re_q       <= di_re_d;
      di_im_q       <= di_im_d;
      outstanding_q <= outstanding_d;
      to_cnt_q      <= to_cnt_d;
      underrun_q    <= underrun_d;
      sop_err_q     <= sop_err_d;
      timeout_q     <= timeout_d;
    end
  end

  fft256_out_framer #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_out_framer (
    .clock       (clock),
    .reset_n     (reset_n),
    .do_en_i     (stg_do_en),
    .do_re_i     (stg_do_re),
    .do_im_i     (stg_do_im),
    .out_valid_o (out_valid),
    .out_sop_o   (out_sop),
    .out_eop_o   (out_eop_w),
    .out_re_o    (out_re),
    .out_im_o    (out_im),
    .frame_cnt_o (frame_cnt),
    .drop_err_o  (drop_err)
  );

  assign out_eop      = out_eop_w;
  assign stg_di_en    = di_en_q;
  assign stg_di_re    = di_re_q;
  assign stg_di_im    = di_im_q;
  assign busy         = (state_q != ST_IDLE);
  assign underrun_err = underrun_q;
  assign sop_err      = sop_err_q;
  assign timeout_err  = timeout_q;

endmodule

// File: doc/fft256_frame_ctrl.md
# fft256_frame_ctrl

Frame sequencer for the 256-point radix-2² SDF stage (FFT256Stg3). It accepts samples from an upstream valid/ready stream and aligns each frame on a start-of-frame marker. It drives the stage's `di_en`/`di_re`/`di_im` with unbroken 256-sample bursts and fills underruns with zeros, so the stage's internal counters never lose alignment. It also frames the stage output with sop/eop markers, counts completed frames and flags protocol errors.

## Interface
- `WIDTH`, 16, sample width per real/imag component
- `N`, 256, samples per frame; power of two
- `TIMEOUT`, 1023, max cycles from the last input sample to the output eop before `timeout_err`
- `clock` in 1: master clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: level; 1 = frames may start, 0 = finish the current frame then drain
- `clr_err` in 1: single-cycle pulse, clears sticky error flags
- `in_valid` in 1: upstream sample valid
- `in_ready` out 1: controller accepts a sample this cycle
- `in_sop` in 1: marks sample 0 of a frame
- `in_re`, `in_im` in WIDTH: upstream sample
- `stg_di_en`, `stg_di_re`, `stg_di_im` out 1/WIDTH/WIDTH: drive to stage inputs
- `stg_do_en`, `stg_do_re`, `stg_do_im` in 1/WIDTH/WIDTH: from stage outputs
- `out_valid`, `out_sop`, `out_eop` out 1: framed output strobes
- `out_re`, `out_im` out WIDTH: framed output data
- `frame_cnt` out 16: completed output frames, wraps
- `busy` out 1: state ≠ IDLE
- `underrun_err`, `sop_err`, `timeout_err` out 1: sticky error flags

## Operation
- States: IDLE, ARM, RUN, DRAIN.
- IDLE: `in_ready`=0. Goes to ARM when `enable`=1.
- ARM: `in_ready`=1. A sample without `in_sop` is discarded silently. A sample with `in_valid`&`in_sop` is accepted as sample 0, and the state goes to RUN with `in_cnt`=1. ARM returns to IDLE when `enable`=0.
- RUN: `stg_di_en` is held at 1 every cycle. `in_ready`=1.
  - If `in_valid`=1, the input sample is forwarded.
  - If `in_valid`=0, zero is forwarded and `underrun_err` is set. The slot still counts.
  - `in_sop`=1 on an accepted sample with `in_cnt`≠0: the sample is forwarded as data and `sop_err` is set. Framing does not change.
- End of frame in RUN, at `in_cnt`=N-1:
  - If `enable`=1 and the same cycle holds `in_valid`&`in_sop` for the next sample, stay in RUN back-to-back. The next frame's sample 0 must land at slot N-1+1 with no gap. `in_ready` is 0 in that cycle only if `enable`=0.
  - Otherwise go to DRAIN.
- DRAIN: `in_ready`=0, `stg_di_en`=0. Go to IDLE when `outstanding`=0. If `timeout_err` is set, go to IDLE immediately.
- `outstanding` is a 2-bit counter. It increments at each input frame end and decrements at each `out_eop`. A simultaneous increment and decrement leaves it unchanged.
- Output framing:
  - `out_cnt` counts registered `stg_do_en` samples modulo N.
  - `out_sop` = (`out_cnt`==0). `out_eop` = (`out_cnt`==N-1).
  - `frame_cnt` increments with each `out_eop`.
  - A `stg_do_en` fall at `out_cnt`≠0 sets `sop_err` and resets `out_cnt` to 0.
- Timeout: a cycle counter starts at each input frame end while `outstanding`>0 and reloads at each `out_eop`. When it reaches TIMEOUT it sets `timeout_err` and forces `outstanding`=0.
- `clr_err` clears all sticky flags. If a set condition occurs in the same cycle, the set wins.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-frame: everything returns to reset values at once. The stage sees `stg_di_en` fall and its own counters restart.

## Timing
- `in_ready` is combinational from state, `in_cnt` and `enable` only. It has no path from `in_valid`.
- `stg_di_*` are registered: an accepted sample appears one cycle after acceptance.
- `out_*` are registered from `stg_do_*`: latency is 1 cycle.
- `out_re`/`out_im` are 0 when `out_valid`=0; X is never propagated.
- The controller makes no assumption about the stage's internal latency. Output framing relies only on `stg_do_en`.
- A burst is exactly N consecutive cycles of `stg_di_en`=1, or k·N for back-to-back frames.

## Structure
- Package `fft256_pkg`:
  - state enum
  - `N_LOG2` = log2(N)
  - `FRAME_CNT_W` = 16
  - timeout counter width = clog2(TIMEOUT+1)
- Sub-module `fft256_out_framer`: output `out_cnt`, sop/eop, `frame_cnt` and the mid-frame drop check. The input FSM, `outstanding` and timeout logic stay in the top level.
- The top-level test harness instantiates this block together with FFT256Stg3.

## Test plan
- Single frame: `in_sop` on sample 0, 256 contiguous valids, ramp data 0..255 → `stg_di_en` high for exactly 256 cycles starting 1 cycle after the first accept; one 256-sample output frame with `out_sop` and `out_eop`; `frame_cnt`=1; `busy` falls after eop.
- Back-to-back: 3 frames with no gaps → `stg_di_en` high for 768 cycles; 3 output eops; `frame_cnt`=3; `outstanding` ≤2 at all times.
- Alignment: 5 samples without sop, then a sop frame → the 5 are discarded; `stg_di_re` of the first burst slot equals the sop sample.
- Underrun: `in_valid` low for cycles 100–109 of a frame → 10 zero slots; burst length still 256; `underrun_err`=1 until `clr_err`.
- Mid-frame sop, plus `enable` dropped during a frame → `sop_err`=1; the current frame completes; no new frame starts; state reaches IDLE after the output eop.
- Reset at input slot 128: `reset_n` pulsed low → all outputs 0 immediately; after release the next sop frame processes normally with `frame_cnt` restarting from 0. With `stg_do_en` tied to 0, `timeout_err` sets after TIMEOUT cycles.
